// File: rtl/button_to_dist_if.sv
// button_to_dist_if: groups the button input and jump outputs of button_to_dist.
//   jump_btn    : debounced button level, 1 = pressed (asynchronous to clk)
//   jump_dist   : last accepted jump distance, held between accepted releases
//   end_of_jump : one-clock pulse when jump_dist is updated
//   charging    : high while a press is being charged
//   charge      : live charge value during a press
// Modports: slave = button_to_dist side, master = driver/consumer side.
interface button_to_dist_if #(
  parameter int unsigned DIST_WIDTH = 8
) ();
  logic                  jump_btn;
  logic [DIST_WIDTH-1:0] jump_dist;
  logic                  end_of_jump;
  logic                  charging;
  logic [DIST_WIDTH-1:0] charge;

  modport master (
    output jump_btn,
    input  jump_dist,
    input  end_of_jump,
    input  charging,
    input  charge
  );

  modport slave (
    input  jump_btn,
    output jump_dist,
    output end_of_jump,
    output charging,
    output charge
  );
endinterface

// File: rtl/button_to_dist.sv
// button_to_dist: converts how long the jump button is held into a jump distance.
// While the synchronized button is high, charge increments once every TICK_CYCLES clocks and
// saturates at MAX_DIST. On release, a charge of at least MIN_DIST is latched into jump_dist
// and end_of_jump pulses for one clock.
// Ports:
//   clk  : master clock, rising edge
//   clr  : asynchronous active-low reset
//   bus  : button_to_dist_if.slave (jump_btn in; jump_dist, end_of_jump, charging, charge out)
// Optional feature: define B2D_AUTOFIRE_EN to fire as soon as charge reaches MAX_DIST, then
// wait for release without a second pulse.
module button_to_dist #(
  parameter int unsigned DIST_WIDTH  = 8,
  parameter int unsigned TICK_CYCLES = 500000,
  parameter int unsigned MIN_DIST    = 2,
  parameter int unsigned MAX_DIST    = 255
) (
  input  logic            clk,
  input  logic            clr,
  button_to_dist_if.slave bus
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]         TickLast = PW'(TICK_CYCLES - 1);
  localparam logic [DIST_WIDTH-1:0] MaxV     = DIST_WIDTH'(MAX_DIST);
  localparam logic [DIST_WIDTH-1:0] MinV     = DIST_WIDTH'(MIN_DIST);

  typedef enum logic [1:0] {StIdle, StCharge, StWaitRelease} state_e;

  state_e                r_state, w_state_d;
  logic                  r_sync1, r_btn_s;
  logic [PW-1:0]         r_presc, w_presc_d;
  logic [DIST_WIDTH-1:0] r_charge, w_charge_d;
  // Accepted release staged for one clock before it reaches jump_dist/end_of_jump.
  logic                  r_pend, w_pend_d;
  logic [DIST_WIDTH-1:0] r_pend_dist, w_pend_dist_d;
  logic [DIST_WIDTH-1:0] r_jump_dist;
  logic                  r_eoj;
  logic                  w_count;

  always_comb begin
    w_state_d     = r_state;
    w_presc_d     = r_presc;
    w_charge_d    = r_charge;
    w_pend_d      = 1'b0;
    w_pend_dist_d = r_pend_dist;
    w_count       = 1'b0;
    unique case (r_state)
      StIdle: begin
        // The clock that leaves IDLE already counts toward the hold length.
        if (r_btn_s) begin
          w_state_d = StCharge;
          w_count   = 1'b1;
        end
      end
      StCharge: begin
`ifdef B2D_AUTOFIRE_EN
        if (r_charge == MaxV) begin
          w_pend_d      = 1'b1;
          w_pend_dist_d = MaxV;
          if (r_btn_s) begin
            w_state_d = StWaitRelease;
          end else begin
            w_state_d  = StIdle;
            w_charge_d = '0;
            w_presc_d  = '0;
          end
        end else
`endif
        if (r_btn_s) begin
          w_count = 1'b1;
        end else begin
          if (r_charge >= MinV) begin
            w_pend_d      = 1'b1;
            w_pend_dist_d = r_charge;
          end
          w_state_d  = StIdle;
          w_charge_d = '0;
          w_presc_d  = '0;
        end
      end
      StWaitRelease: begin
        if (!r_btn_s) begin
          w_state_d  = StIdle;
          w_charge_d = '0;
          w_presc_d  = '0;
        end
      end
      default: begin
        w_state_d  = StIdle;
        w_charge_d = '0;
        w_presc_d  = '0;
      end
    endcase
    if (w_count) begin
      if (r_presc == TickLast) begin
        w_presc_d = '0;
        if (r_charge < MaxV) w_charge_d = r_charge + 1'b1;
      end else begin
        w_presc_d = r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1     <= 1'b0;
      r_btn_s     <= 1'b0;
      r_state     <= StIdle;
      r_presc     <= '0;
      r_charge    <= '0;
      r_pend      <= 1'b0;
      r_pend_dist <= '0;
      r_jump_dist <= '0;
      r_eoj       <= 1'b0;
    end else begin
      r_sync1     <= bus.jump_btn;
      r_btn_s     <= r_sync1;
      r_state     <= w_state_d;
      r_presc     <= w_presc_d;
      r_charge    <= w_charge_d;
      r_pend      <= w_pend_d;
      r_pend_dist <= w_pend_dist_d;
      r_eoj       <= r_pend;
      if (r_pend) r_jump_dist <= r_pend_dist;
    end
  end

  assign bus.jump_dist   = r_jump_dist;
  assign bus.end_of_jump = r_eoj;
  assign bus.charging    = (r_state == StCharge);
  assign bus.charge      = r_charge;

endmodule

// File: tb/tb_button_to_dist.sv
module tb_button_to_dist;

`ifdef B2D_AUTOFIRE_EN
  localparam int Af   = 1;
  localparam int BMax = 10;
`else
  localparam int Af   = 0;
  localparam int BMax = 255;
`endif
  localparam int MinD = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  button_to_dist_if #(.DIST_WIDTH(8)) bus_a ();
  button_to_dist_if #(.DIST_WIDTH(8)) bus_b ();

  // Instance A: slow prescaler; instance B: one count per clock.
  button_to_dist #(.DIST_WIDTH(8), .TICK_CYCLES(4), .MIN_DIST(MinD), .MAX_DIST(255)) u_dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a)
  );
  button_to_dist #(.DIST_WIDTH(8), .TICK_CYCLES(1), .MIN_DIST(MinD), .MAX_DIST(BMax)) u_dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_dist[2];
  logic [7:0] s_charge, s_dist;
  logic       s_charging, s_eoj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel != 0) bus_b.jump_btn = v;
    else bus_a.jump_btn = v;
  endtask

  task automatic step(input int sel);
    @(posedge clk);
    @(negedge clk);
    s_charge   = (sel != 0) ? bus_b.charge : bus_a.charge;
    s_dist     = (sel != 0) ? bus_b.jump_dist : bus_a.jump_dist;
    s_charging = (sel != 0) ? bus_b.charging : bus_a.charging;
    s_eoj      = (sel != 0) ? bus_b.end_of_jump : bus_a.end_of_jump;
  endtask

  // Hold the button for len clocks, release, and compare against the hold-length rule.
  task automatic press(input int sel, input int len, input int gap);
    int t, mx, held, exp_c, ntot, nrel, relidx, pval;
    bit autof;
    t     = (sel != 0) ? 1 : 4;
    mx    = (sel != 0) ? BMax : 255;
    autof = (Af != 0) && (len >= mx * t);
    ntot = 0; nrel = 0; relidx = 0; pval = -1;
    drive(sel, 1'b1);
    for (int i = 1; i <= len; i++) begin
      step(sel);
      // Two synchronizer clocks pass before the first high clock is counted.
      exp_c = (i >= 2) ? (i - 2) / t : 0;
      if (exp_c > mx) exp_c = mx;
      check("hold_charge", 32'(s_charge), 32'(exp_c));
      check("hold_charging", 32'(s_charging),
            32'((i >= 3) && !(autof && i >= mx * t + 3)));
      if (s_eoj === 1'b1) begin ntot++; pval = s_dist; end
    end
    drive(sel, 1'b0);
    for (int r = 1; r <= gap; r++) begin
      step(sel);
      if (s_eoj === 1'b1) begin ntot++; nrel++; relidx = r; pval = s_dist; end
    end
    held = len / t;
    if (held > mx) held = mx;
    if (autof) begin
      check("autofire_pulses", 32'(ntot), 32'd1);
      check("autofire_value", 32'(pval), 32'(mx));
      exp_dist[sel] = mx;
    end else if (held >= MinD) begin
      check("release_pulses", 32'(ntot), 32'd1);
      check("release_latency", 32'(relidx), 32'd4);
      check("release_value", 32'(pval), 32'(held));
      exp_dist[sel] = held;
    end else begin
      check("short_no_pulse", 32'(ntot), 32'd0);
    end
    check("dist_held", 32'(s_dist), 32'(exp_dist[sel]));
    check("idle_charge", 32'(s_charge), 32'd0);
    check("idle_charging", 32'(s_charging), 32'd0);
    check("other_dist", 32'((sel != 0) ? bus_a.jump_dist : bus_b.jump_dist),
          32'(exp_dist[1 - sel]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_dist[0] = 0;
    exp_dist[1] = 0;
    bus_a.jump_btn = 1'b0;
    bus_b.jump_btn = 1'b0;

    // Reset held with the buttons toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_a.jump_btn = ~bus_a.jump_btn;
      bus_b.jump_btn = ~bus_b.jump_btn;
    end
    @(negedge clk);
    check("rst_dist_a", 32'(bus_a.jump_dist), 32'd0);
    check("rst_eoj_a", 32'(bus_a.end_of_jump), 32'd0);
    check("rst_charging_a", 32'(bus_a.charging), 32'd0);
    check("rst_charge_a", 32'(bus_a.charge), 32'd0);
    check("rst_dist_b", 32'(bus_b.jump_dist), 32'd0);
    check("rst_eoj_b", 32'(bus_b.end_of_jump), 32'd0);
    check("rst_charging_b", 32'(bus_b.charging), 32'd0);
    check("rst_charge_b", 32'(bus_b.charge), 32'd0);
    bus_a.jump_btn = 1'b0;
    bus_b.jump_btn = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) step(0);
    check("post_rst_charging", 32'(s_charging), 32'd0);
    check("post_rst_charge", 32'(s_charge), 32'd0);

    // Basic press, then stability over 100 clocks.
    press(0, 21, 8);
    for (int i = 0; i < 100; i++) begin
      step(0);
      if (s_eoj !== 1'b0 || s_dist !== 8'd5) check("dist_stable", 32'(s_dist), 32'd5);
    end
    check("dist_stable_end", 32'(s_dist), 32'd5);

    // Short press leaves the previous distance.
    press(0, 6, 8);

    // Saturation on B (autofire instead when the feature is built in).
    press(1, 400, 8);
    press(1, 50, 8);
    press(1, 7, 8);

    // Mid-press reset on A.
    drive(0, 1'b1);
    for (int i = 0; i < 12; i++) step(0);
    clr = 1'b0;
    step(0);
    check("midrst_charge", 32'(s_charge), 32'd0);
    check("midrst_dist", 32'(s_dist), 32'd0);
    check("midrst_eoj", 32'(s_eoj), 32'd0);
    check("midrst_dist_b", 32'(bus_b.jump_dist), 32'd0);
    exp_dist[0] = 0;
    exp_dist[1] = 0;
    clr = 1'b1;
    drive(0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(0);
      if (s_eoj !== 1'b0) check("midrst_no_pulse", 32'(s_eoj), 32'd0);
    end
    press(0, 16, 8);

    // Randomized presses on both instances.
    for (int n = 0; n < 10; n++) press(0, int'($urandom_range(40, 1)), 8);
    for (int n = 0; n < 8; n++) press(1, int'($urandom_range(300, 1)), 8);
    press(1, 2, 8);
    press(1, 1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_to_dist.md
Name: button_to_dist

Overview:
- Converts the duration of a debounced jump button press into an 8-bit jump distance for the game FSM.
- While the button is held, a charge counter increments once every TICK_CYCLES clocks and saturates at MAX_DIST.
- On release, the charge is latched into jump_dist and end_of_jump pulses for one clock.
- Sits between the button debouncer and the game state machine, in the master-clock domain.

Parameters:
- DIST_WIDTH, 8: width of jump_dist and charge.
- TICK_CYCLES, 500000: clocks per charge increment (10 ms at 50 MHz); legal range is 1 or more.
- MIN_DIST, 2: releases with charge below this value are ignored.
- MAX_DIST, 255: saturation value of charge; must be at most 2^DIST_WIDTH-1.

Ports:
- clk  in  1  master clock; all logic on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- jump_btn  in  1  debounced button level; 1 = pressed; asynchronous to clk.
- jump_dist  out  DIST_WIDTH  last accepted jump distance; held until the next accepted release.
- end_of_jump  out  1  one-clock pulse when jump_dist is updated.
- charging  out  1  high while a press is being charged.
- charge  out  DIST_WIDTH  live charge value during a press.

Behaviour:
- Reset (clr=0, asynchronous):
  - Outputs: jump_dist=0, end_of_jump=0, charging=0, charge=0.
  - State goes to IDLE; synchronizer flops and the prescaler clear.
- Input synchronization: jump_btn passes through 2 flops to give btn_s. All decisions use btn_s.
- Hold-length rule: H is the number of consecutive clocks btn_s is high. At release, charge = min(floor(H/TICK_CYCLES), MAX_DIST).
- IDLE:
  - charging=0, charge=0.
  - btn_s=1 goes to CHARGE; that first high clock counts toward H.
- CHARGE:
  - charging=1.
  - The prescaler counts clocks; at each TICK_CYCLES boundary charge increments, saturating at MAX_DIST. It never wraps.
  - btn_s=0 with charge>=MIN_DIST: on the next edge jump_dist<=charge, end_of_jump=1 for exactly one clock, go to IDLE.
  - btn_s=0 with charge<MIN_DIST: no pulse, jump_dist unchanged, go to IDLE.
- WAIT_RELEASE: used only with the optional feature. charging=0; stay until btn_s=0, then go to IDLE. No output change.
- Latency: jump_btn first sampled low at edge N means end_of_jump is high for the cycle following edge N+3, and jump_dist is valid from that same edge.
- charge returns to 0 on the edge that enters IDLE.
- jump_dist is stable between accepted releases, so the slower render-clock FSM can sample it safely.
- A press starting in the same cycle end_of_jump is high is handled normally. The new press cannot alter the jump_dist just latched.
- Reset asserted mid-press aborts the press: no pulse, and jump_dist returns to 0.

Optional Feature:
- Macro: B2D_AUTOFIRE_EN.
- Defined:
  - When charge reaches MAX_DIST in CHARGE, on the next edge jump_dist<=MAX_DIST and end_of_jump pulses without waiting for release.
  - FSM then goes to WAIT_RELEASE; the later release produces no second pulse.
- Undefined:
  - WAIT_RELEASE is unreachable.
  - Charge saturates at MAX_DIST and fires only on release.

Test Plan:
- Reset: hold clr=0 for 5 clocks with jump_btn toggling -> all outputs 0; after release of clr the state is IDLE.
- Basic press (TICK_CYCLES=4): jump_btn high for 21 clocks, then low -> exactly one end_of_jump pulse, jump_dist=5, 3 edges after the first low sample. jump_dist stays 5 for 100 further clocks.
- Short press (TICK_CYCLES=4, MIN_DIST=2): high for 6 clocks (charge=1) -> no end_of_jump, jump_dist keeps its previous value (5).
- Saturation (TICK_CYCLES=1, MAX_DIST=255, macro off): high for 400 clocks -> charge holds at 255 from clock 255 onward, no pulse while held. On release, jump_dist=255 with one pulse.
- Autofire (B2D_AUTOFIRE_EN, TICK_CYCLES=1, MAX_DIST=10): high for 50 clocks -> single pulse with jump_dist=10 shortly after charge reaches 10. No pulse on release; the next press works normally.
- Mid-press reset (TICK_CYCLES=4): after 12 high clocks drive clr=0 for 1 clock -> charge=0, jump_dist=0, no pulse. A subsequent clean 16-clock press gives jump_dist=4.
